// File: rtl/full_hash_wide_if.sv
// ----------------------------------------------------------------------------
// full_hash_wide_if
// Handshake/bus bundle between the byte/word source, the full_hash_wide core
// and the result consumer.
//   start       : begin a new message (one-cycle pulse)
//   Data        : beat payload, byte 0 = Data[7:0] hashed first
//   Byte_cnt    : number of valid bytes in the beat, from byte 0 upward
//   F_dr        : source data ready (four-phase request)
//   End_of_File : message end request
//   R_h         : final hash
//   F_rtr       : core ready to receive
//   H_ready     : R_h valid
//   Msg_len     : bytes hashed in the current/last message
// master = source/consumer side, slave = hash core side.
// ----------------------------------------------------------------------------
interface full_hash_wide_if #(
    parameter int DATA_BYTES = 4,
    parameter int HASH_W     = 32,
    parameter int LEN_W      = 32
);
    localparam int CNT_W = $clog2(DATA_BYTES + 1);

    logic                    start;
    logic [8*DATA_BYTES-1:0] Data;
    logic [CNT_W-1:0]        Byte_cnt;
    logic                    F_dr;
    logic                    End_of_File;
    logic [HASH_W-1:0]       R_h;
    logic                    F_rtr;
    logic                    H_ready;
    logic [LEN_W-1:0]        Msg_len;

    modport master (
        output start, Data, Byte_cnt, F_dr, End_of_File,
        input  R_h, F_rtr, H_ready, Msg_len
    );

    modport slave (
        input  start, Data, Byte_cnt, F_dr, End_of_File,
        output R_h, F_rtr, H_ready, Msg_len
    );
endinterface

// File: rtl/full_hash_wide.sv
// ----------------------------------------------------------------------------
// full_hash_wide
// Multi-byte-per-beat rotate-xor hash core. Each accepted beat carries up to
// DATA_BYTES bytes; the core hashes them one per cycle as
// H = rotl(H, ROT) ^ byte, counts them in Msg_len and, on end of message,
// publishes R_h = H ^ Msg_len with H_ready.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : full_hash_wide_if.slave (start, Data, Byte_cnt, F_dr,
//           End_of_File in; R_h, F_rtr, H_ready, Msg_len out)
// ----------------------------------------------------------------------------
module full_hash_wide #(
    parameter int          DATA_BYTES = 4,
    parameter int          HASH_W     = 32,
    parameter int          ROT        = 5,
    parameter logic [31:0] INIT       = 32'h811C9DC5,
    parameter int          LEN_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    full_hash_wide_if.slave  bus
);

    localparam int                CNT_W   = $clog2(DATA_BYTES + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(DATA_BYTES);
    localparam logic [HASH_W-1:0] INIT_H  = HASH_W'(INIT);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DR   = 3'd1,
        PROC      = 3'd2,
        WAIT_DROP = 3'd3,
        FINAL     = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [8*DATA_BYTES-1:0] data_q;
    logic [CNT_W-1:0]        rem_q;
    logic                    eof_pend_q;
    logic [HASH_W-1:0]       h_q;
    logic [LEN_W-1:0]        len_q;
    logic [HASH_W-1:0]       rh_q;

    logic [CNT_W-1:0]        cnt_in;
    logic                    init_en;
    logic                    accept;
    logic                    proc_en;
    logic                    final_en;
    logic                    f_rtr;
    logic                    h_ready;

    function automatic logic [HASH_W-1:0] rotl(input logic [HASH_W-1:0] x);
        return (x << ROT) | (x >> (HASH_W - ROT));
    endfunction

    function automatic logic [HASH_W-1:0] zext_byte(input logic [7:0] b);
        return {{(HASH_W-8){1'b0}}, b};
    endfunction

    // Oversized counts are treated as a full beat.
    assign cnt_in = (bus.Byte_cnt > MAX_CNT) ? MAX_CNT : bus.Byte_cnt;

    // ---- state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) state_nxt = WAIT_DR;
            end
            WAIT_DR: begin
                if (bus.F_dr) begin
                    state_nxt = (cnt_in == '0) ? WAIT_DROP : PROC;
                end else if (bus.End_of_File) begin
                    state_nxt = FINAL;
                end
            end
            PROC: begin
                if (rem_q == CNT_W'(1)) state_nxt = WAIT_DROP;
            end
            WAIT_DROP: begin
                // Four-phase: the source must drop F_dr before the next beat.
                if (!bus.F_dr) state_nxt = eof_pend_q ? FINAL : WAIT_DR;
            end
            FINAL:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- outputs and datapath strobes ----
    always_comb begin
        f_rtr    = 1'b0;
        h_ready  = 1'b0;
        init_en  = 1'b0;
        accept   = 1'b0;
        proc_en  = 1'b0;
        final_en = 1'b0;
        unique case (state)
            IDLE:      init_en = bus.start;
            WAIT_DR: begin
                f_rtr  = 1'b1;
                accept = bus.F_dr;
            end
            PROC:      proc_en = 1'b1;
            WAIT_DROP: ;
            FINAL:     final_en = 1'b1;
            DONE: begin
                h_ready = 1'b1;
                init_en = bus.start;
            end
            default: ;
        endcase
    end

    // Beat payload is only consumed in PROC, so it needs no reset; it is
    // shifted down so the next byte to hash is always in the low lane.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_q <= bus.Data;
        end else if (proc_en) begin
            data_q <= data_q >> 8;
        end
    end

    // ---- hash, length and result registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q        <= INIT_H;
            len_q      <= '0;
            rh_q       <= '0;
            rem_q      <= '0;
            eof_pend_q <= 1'b0;
        end else begin
            if (init_en) begin
                h_q   <= INIT_H;
                len_q <= '0;
            end
            if (accept) begin
                rem_q      <= cnt_in;
                eof_pend_q <= bus.End_of_File;
            end
            if (proc_en) begin
                h_q   <= rotl(h_q) ^ zext_byte(data_q[7:0]);
                len_q <= len_q + LEN_W'(1);
                rem_q <= rem_q - CNT_W'(1);
            end
            if (final_en) begin
                rh_q <= h_q ^ HASH_W'(len_q);
            end
        end
    end

    assign bus.R_h     = rh_q;
    assign bus.Msg_len = len_q;
    assign bus.F_rtr   = f_rtr;
    assign bus.H_ready = h_ready;

endmodule

// File: tb/tb_full_hash_wide.sv
// ----------------------------------------------------------------------------
// tb_full_hash_wide
// Directed bench for full_hash_wide. Four instances share clk/rst_n:
//   0: INIT=0, DATA_BYTES=1     1: defaults, DATA_BYTES=4
//   2: defaults, DATA_BYTES=1   3: INIT=0, DATA_BYTES=4
// Expected hashes are worked out by hand from H = rotl5(H) ^ byte,
// R_h = H ^ length.
// ----------------------------------------------------------------------------
module tb_full_hash_wide;

    localparam logic [31:0] CIAO_H = 32'h095EC495;  // "CiaoMondo", default INIT
    localparam logic [31:0] DEF_I  = 32'h811C9DC5;

    logic clk;
    logic rst_n;

    logic        start_s [4];
    logic [31:0] data_s  [4];
    logic [2:0]  cnt_s   [4];
    logic        fdr_s   [4];
    logic        eof_s   [4];
    logic [31:0] rh_s    [4];
    logic        frtr_s  [4];
    logic        hrdy_s  [4];
    logic [31:0] len_s   [4];

    int checks;
    int errors;

    logic [7:0] ciao [9];

    full_hash_wide_if #(.DATA_BYTES(1)) if0 ();
    full_hash_wide_if #(.DATA_BYTES(4)) if1 ();
    full_hash_wide_if #(.DATA_BYTES(1)) if2 ();
    full_hash_wide_if #(.DATA_BYTES(4)) if3 ();

    full_hash_wide #(.DATA_BYTES(1), .INIT(32'h0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    full_hash_wide #(.DATA_BYTES(4))               u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    full_hash_wide #(.DATA_BYTES(1))               u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    full_hash_wide #(.DATA_BYTES(4), .INIT(32'h0)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    assign if0.start = start_s[0];  assign if0.Data = data_s[0][7:0];
    assign if0.Byte_cnt = cnt_s[0][0:0];  assign if0.F_dr = fdr_s[0];
    assign if0.End_of_File = eof_s[0];
    assign if1.start = start_s[1];  assign if1.Data = data_s[1];
    assign if1.Byte_cnt = cnt_s[1];  assign if1.F_dr = fdr_s[1];
    assign if1.End_of_File = eof_s[1];
    assign if2.start = start_s[2];  assign if2.Data = data_s[2][7:0];
    assign if2.Byte_cnt = cnt_s[2][0:0];  assign if2.F_dr = fdr_s[2];
    assign if2.End_of_File = eof_s[2];
    assign if3.start = start_s[3];  assign if3.Data = data_s[3];
    assign if3.Byte_cnt = cnt_s[3];  assign if3.F_dr = fdr_s[3];
    assign if3.End_of_File = eof_s[3];

    assign rh_s[0] = if0.R_h;  assign frtr_s[0] = if0.F_rtr;
    assign hrdy_s[0] = if0.H_ready;  assign len_s[0] = if0.Msg_len;
    assign rh_s[1] = if1.R_h;  assign frtr_s[1] = if1.F_rtr;
    assign hrdy_s[1] = if1.H_ready;  assign len_s[1] = if1.Msg_len;
    assign rh_s[2] = if2.R_h;  assign frtr_s[2] = if2.F_rtr;
    assign hrdy_s[2] = if2.H_ready;  assign len_s[2] = if2.Msg_len;
    assign rh_s[3] = if3.R_h;  assign frtr_s[3] = if3.F_rtr;
    assign hrdy_s[3] = if3.H_ready;  assign len_s[3] = if3.Msg_len;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rtr(input int s, input string tag);
        int n = 0;
        while (!frtr_s[s] && n < 100) begin
            step();
            n++;
        end
        chk(tag, 64'(frtr_s[s]), 64'd1);
    endtask

    task automatic wait_done(input int s, input string tag);
        int n = 0;
        while (!hrdy_s[s] && n < 100) begin
            step();
            n++;
        end
        chk(tag, 64'(hrdy_s[s]), 64'd1);
    endtask

    task automatic start_msg(input int s);
        start_s[s] = 1'b1;
        step();
        start_s[s] = 1'b0;
    endtask

    task automatic send_beat(input int s, input logic [31:0] d, input logic [2:0] n,
                             input logic e);
        wait_rtr(s, "beat_rtr");
        data_s[s] = d;
        cnt_s[s]  = n;
        fdr_s[s]  = 1'b1;
        eof_s[s]  = e;
        step();
        fdr_s[s]  = 1'b0;
        eof_s[s]  = 1'b0;
    endtask

    task automatic send_eof(input int s);
        wait_rtr(s, "eof_rtr");
        eof_s[s] = 1'b1;
        step();
        eof_s[s] = 1'b0;
    endtask

    task automatic send_ciao_wide();
        send_beat(1, 32'h6F616943, 3'd4, 1'b0);
        send_beat(1, 32'h646E6F4D, 3'd4, 1'b0);
        send_beat(1, 32'h0000006F, 3'd1, 1'b1);
    endtask

    initial begin
        int cyc;
        int rtr_hi;
        checks = 0;
        errors = 0;
        ciao = '{8'h43, 8'h69, 8'h61, 8'h6F, 8'h4D, 8'h6F, 8'h6E, 8'h64, 8'h6F};
        for (int i = 0; i < 4; i++) begin
            start_s[i] = 1'b0;
            data_s[i]  = '0;
            cnt_s[i]   = '0;
            fdr_s[i]   = 1'b0;
            eof_s[i]   = 1'b0;
        end
        rst_n = 1'b0;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            chk("rst_rh",   64'(rh_s[i]),   64'd0);
            chk("rst_hrdy", 64'(hrdy_s[i]), 64'd0);
            chk("rst_frtr", 64'(frtr_s[i]), 64'd0);
            chk("rst_len",  64'(len_s[i]),  64'd0);
        end
        rst_n = 1'b1;
        step();

        // 'A','B' byte-serial with INIT=0: 0x41 -> 0x862, ^2 -> 0x860
        start_msg(0);
        send_beat(0, 32'h41, 3'd1, 1'b0);
        send_beat(0, 32'h42, 3'd1, 1'b0);
        send_eof(0);
        wait_done(0, "ab_done");
        chk("ab_rh",  64'(rh_s[0]),  64'h860);
        chk("ab_len", 64'(len_s[0]), 64'd2);

        // Empty message: EOF at edge t -> FINAL, DONE after t+1
        start_msg(1);
        wait_rtr(1, "empty_rtr");
        eof_s[1] = 1'b1;
        step();
        eof_s[1] = 1'b0;
        chk("empty_t_hrdy", 64'(hrdy_s[1]), 64'd0);
        chk("empty_t_frtr", 64'(frtr_s[1]), 64'd0);
        step();
        chk("empty_t1_hrdy", 64'(hrdy_s[1]), 64'd1);
        chk("empty_rh",      64'(rh_s[1]),   64'(DEF_I));
        chk("empty_len",     64'(len_s[1]),  64'd0);

        // Two bytes plus EOF in one beat: PROC, PROC, WAIT_DROP, FINAL, DONE
        start_msg(3);
        wait_rtr(3, "beat_eof_rtr");
        data_s[3] = 32'h00004241;
        cnt_s[3]  = 3'd2;
        fdr_s[3]  = 1'b1;
        eof_s[3]  = 1'b1;
        step();
        fdr_s[3]  = 1'b0;
        eof_s[3]  = 1'b0;
        cyc = 0;
        rtr_hi = 0;
        while (!hrdy_s[3] && cyc < 20) begin
            if (frtr_s[3]) rtr_hi++;
            step();
            cyc++;
        end
        chk("beat_eof_lat",   64'(cyc),      64'd4);
        chk("beat_eof_rtrhi", 64'(rtr_hi),   64'd0);
        chk("beat_eof_rh",    64'(rh_s[3]),  64'h860);
        chk("beat_eof_len",   64'(len_s[3]), 64'd2);

        // Byte_cnt 7 clamps to 4: 41,42,43,44 -> 0x218024, ^4 -> 0x218020
        start_msg(3);
        send_beat(3, 32'h44434241, 3'd7, 1'b1);
        wait_done(3, "clamp_done");
        chk("clamp_rh",  64'(rh_s[3]),  64'h218020);
        chk("clamp_len", 64'(len_s[3]), 64'd4);

        // Zero-count beat hashes nothing: then 0x41 -> 0x41 ^ 1 = 0x40
        start_msg(3);
        send_beat(3, 32'hFFFFFFFF, 3'd0, 1'b0);
        send_beat(3, 32'h00000041, 3'd1, 1'b1);
        wait_done(3, "zero_done");
        chk("zero_rh",  64'(rh_s[3]),  64'h40);
        chk("zero_len", 64'(len_s[3]), 64'd1);

        // "CiaoMondo" byte-serial
        start_msg(2);
        for (int i = 0; i < 9; i++) send_beat(2, {24'h0, ciao[i]}, 3'd1, 1'b0);
        send_eof(2);
        wait_done(2, "ser_done");
        chk("ser_rh",  64'(rh_s[2]),  64'(CIAO_H));
        chk("ser_len", 64'(len_s[2]), 64'd9);

        // "CiaoMondo" 4+4+1 with a stray start during PROC of beat 1
        start_msg(1);
        send_beat(1, 32'h6F616943, 3'd4, 1'b0);
        start_msg(1);
        send_beat(1, 32'h646E6F4D, 3'd4, 1'b0);
        send_beat(1, 32'h0000006F, 3'd1, 1'b1);
        wait_done(1, "wide_done");
        chk("wide_rh",  64'(rh_s[1]),  64'(CIAO_H));
        chk("wide_len", 64'(len_s[1]), 64'd9);

        // New start clears H_ready but R_h holds the previous result
        start_msg(1);
        chk("restart_hrdy", 64'(hrdy_s[1]), 64'd0);
        chk("restart_rh",   64'(rh_s[1]),   64'(CIAO_H));

        // Reset in the middle of PROC of the second beat
        send_beat(1, 32'h6F616943, 3'd4, 1'b0);
        send_beat(1, 32'h646E6F4D, 3'd4, 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_rh",   64'(rh_s[1]),   64'd0);
        chk("midrst_len",  64'(len_s[1]),  64'd0);
        chk("midrst_hrdy", 64'(hrdy_s[1]), 64'd0);
        chk("midrst_frtr", 64'(frtr_s[1]), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        step();
        chk("postrst_frtr", 64'(frtr_s[1]), 64'd0);
        chk("postrst_rh",   64'(rh_s[1]),   64'd0);
        start_msg(1);
        send_ciao_wide();
        wait_done(1, "resend_done");
        chk("resend_rh",  64'(rh_s[1]),  64'(CIAO_H));
        chk("resend_len", 64'(len_s[1]), 64'd9);

        // Source holds F_dr for 500 cycles after acceptance
        start_msg(1);
        wait_rtr(1, "hold_rtr");
        data_s[1] = 32'h6F616943;
        cnt_s[1]  = 3'd4;
        fdr_s[1]  = 1'b1;
        step();
        rtr_hi = 0;
        for (int i = 0; i < 500; i++) begin
            if (frtr_s[1]) rtr_hi++;
            step();
        end
        chk("hold_rtrhi", 64'(rtr_hi),   64'd0);
        chk("hold_len",   64'(len_s[1]), 64'd4);
        fdr_s[1] = 1'b0;
        send_beat(1, 32'h646E6F4D, 3'd4, 1'b0);
        send_beat(1, 32'h0000006F, 3'd1, 1'b1);
        wait_done(1, "hold_done");
        chk("hold_rh",  64'(rh_s[1]),  64'(CIAO_H));
        chk("hold_len9", 64'(len_s[1]), 64'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
